// File: rtl/mult_pkg.sv
// Shared types and default sizing for the digit-serial multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 16;

endpackage

// File: rtl/mult_digit.sv
// Combinational unsigned DIGIT x DIGIT multiply, the only multiplier in the datapath.
module mult_digit
  import mult_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0]   i_x,
  input  logic [DIGIT-1:0]   i_y,
  output logic [2*DIGIT-1:0] o_p
);

  assign o_p = (2*DIGIT)'(i_x) * (2*DIGIT)'(i_y);

endmodule

// File: rtl/mult_param_fast.sv
// Sign-magnitude multiplier that accumulates one digit partial product per cycle,
// skipping leading zero digits of either operand.
module mult_param_fast
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = 2 * WIDTH;
  localparam int SHW  = $clog2(PW);

  state_t r_state, w_state_next;

  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [WIDTH-1:0]   r_a_mag, r_b_mag;
  logic               r_neg;
  logic [IW-1:0]      r_i, r_j, r_ka_m1, r_kb_m1;
  logic [IW-1:0]      w_ka_m1, w_kb_m1;
  logic [NDIG-1:0]    w_a_nz, w_b_nz;
  logic [DIGIT-1:0]   w_a_digits [NDIG];
  logic [DIGIT-1:0]   w_b_digits [NDIG];
  logic [2*DIGIT-1:0] w_pp;
  logic [SHW-1:0]     w_shamt;
  logic [PW-1:0]      w_pp_shifted;
  logic [PW-1:0]      r_acc, r_product;
  logic               r_done;
  logic               w_last;

  // Magnitudes; the most negative value maps to 2^(WIDTH-1) as plain unsigned.
  assign w_a_abs = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign w_b_abs = (signed_mode && b[WIDTH-1]) ? -b : b;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digits
      assign w_a_nz[gi]     = |w_a_abs[gi*DIGIT +: DIGIT];
      assign w_b_nz[gi]     = |w_b_abs[gi*DIGIT +: DIGIT];
      assign w_a_digits[gi] = r_a_mag[gi*DIGIT +: DIGIT];
      assign w_b_digits[gi] = r_b_mag[gi*DIGIT +: DIGIT];
    end
  endgenerate

  // Digit counts stored minus one; a zero operand collapses both to a single digit.
  always_comb begin
    w_ka_m1 = '0;
    w_kb_m1 = '0;
    if ((|w_a_nz) && (|w_b_nz)) begin
      for (int k = 0; k < NDIG; k++) begin
        if (w_a_nz[k]) w_ka_m1 = IW'(k);
        if (w_b_nz[k]) w_kb_m1 = IW'(k);
      end
    end
  end

  mult_digit #(.DIGIT(DIGIT)) u_mult_digit (
    .i_x(w_a_digits[r_i]),
    .i_y(w_b_digits[r_j]),
    .o_p(w_pp)
  );

  assign w_shamt      = SHW'((32'(r_i) + 32'(r_j)) * DIGIT);
  assign w_pp_shifted = PW'(w_pp) << w_shamt;
  assign w_last       = (r_i == r_ka_m1) && (r_j == r_kb_m1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = MULT;
      MULT:    if (w_last) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_neg     <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_ka_m1   <= '0;
      r_kb_m1   <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_mag <= w_a_abs;
            r_b_mag <= w_b_abs;
            r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_ka_m1 <= w_ka_m1;
            r_kb_m1 <= w_kb_m1;
            r_i     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
          end
        end
        MULT: begin
          r_acc <= r_acc + w_pp_shifted;
          if (r_j == r_kb_m1) begin
            r_j <= '0;
            r_i <= r_i + IW'(1);
          end else begin
            r_j <= r_j + IW'(1);
          end
        end
        FIX: begin
          r_product <= r_neg ? -r_acc : r_acc;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_mult_param_fast.sv
// Directed bench for mult_param_fast with a cycle-level reference model and
// literal result/latency expectations.
module tb_mult_param_fast;

  logic        clk = 1'b0;
  logic        reset, start, signed_mode;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_param_fast #(.WIDTH(32), .DIGIT(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
    .signed_mode(signed_mode),
    .busy(busy),
    .done(done),
    .product(product)
  );

  function automatic logic [31:0] mag_of(input logic [31:0] x, input logic sm);
    return (sm && x[31]) ? -x : x;
  endfunction

  function automatic int digits_of(input logic [31:0] m);
    return (m[31:16] != 16'd0) ? 2 : 1;
  endfunction

  function automatic int lat_of(input logic [31:0] x, input logic [31:0] y, input logic sm);
    logic [31:0] mx, my;
    mx = mag_of(x, sm);
    my = mag_of(y, sm);
    if (mx == 32'd0 || my == 32'd0) return 2;
    return digits_of(mx) * digits_of(my) + 1;
  endfunction

  function automatic logic [63:0] prod_of(input logic [31:0] x, input logic [31:0] y, input logic sm);
    longint sx, sy;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks accepted operations by edge number.
  int          cyc = 0;
  bit          m_valid = 1'b0;
  bit          m_active = 1'b0;
  int          m_e0 = 0;
  int          m_done_edge = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_next = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_valid  <= 1'b1;
      m_active <= 1'b0;
      m_prod   <= '0;
    end else begin
      if (m_active && (cyc + 1 == m_done_edge)) m_prod <= m_next;
      if ((!m_active || (cyc + 1 > m_done_edge)) && start) begin
        m_active    <= 1'b1;
        m_e0        <= cyc + 1;
        m_done_edge <= cyc + 1 + lat_of(a, b, signed_mode);
        m_next      <= prod_of(a, b, signed_mode);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check64("busy", 64'(busy),
              64'(m_active && (cyc >= m_e0) && (cyc < m_done_edge)));
      check64("done", 64'(done), 64'(m_active && (cyc == m_done_edge)));
      check64("product", product, m_prod);
    end
  end

  // Launch one operation; scramble operands while busy and optionally re-pulse start.
  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic sm, input bit glitch,
                        input logic [63:0] exp_lit, input int lat_lit);
    int cnt;
    bit seen;
    a = x; b = y; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    cnt  = 0;
    seen = 1'b0;
    while (cnt < 20 && !seen) begin
      @(negedge clk);
      start       = (glitch && cnt == 0);
      a           = $urandom;
      b           = $urandom;
      signed_mode = 1'($urandom_range(0, 1));
      @(posedge clk);
      cnt++;
      #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout done not seen within %0d cycles", name, cnt);
    end else begin
      check64({name, "_latency"}, 64'(cnt), 64'(lat_lit));
      check64({name, "_result"}, product, exp_lit);
    end
    $display("op %s a=%h b=%h signed=%0d product=%h latency=%0d", name, x, y, sm, product, cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check64("reset_busy", 64'(busy), 64'd0);
    check64("reset_done", 64'(done), 64'd0);
    check64("reset_product", product, 64'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    run_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 5);
    run_op("u_small_b2b", 32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0, 64'h0000_0000_0001_2340, 2);
    repeat (2) @(negedge clk);
    run_op("s_neg3x7", 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 2);
    run_op("s_minsq_glitch", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, 5);
    run_op("u_zero", 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'd0, 2);
    run_op("s_mixed", 32'h0001_2345, 32'hFFFF_0000, 1'b1, 1'b0, 64'hFFFF_FFFE_DCBB_0000, 5);
    run_op("u_2x1", 32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0, 64'h0000_0000_FFFF_0000, 3);

    // Reset during the second MULT cycle, with start held to show reset wins.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    @(negedge clk) begin reset = 1'b1; start = 1'b1; end
    @(posedge clk);
    #1;
    check64("midreset_busy", 64'(busy), 64'd0);
    check64("midreset_done", 64'(done), 64'd0);
    check64("midreset_product", product, 64'd0);
    $display("op midreset busy=%0d done=%0d product=%h", busy, done, product);
    @(negedge clk) begin reset = 1'b0; start = 1'b0; end
    @(negedge clk);

    run_op("u_after_reset", 32'h0000_ABCD, 32'h0000_1234, 1'b0, 1'b0, 64'h0000_0000_0C37_4FA4, 2);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_param_fast.md
MULT_PARAM_FAST -- requirements
Module: mult_param_fast

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 16, digit width used per partial-product cycle.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-006 a  input  WIDTH  multiplicand; sampled on the accepting edge only.
REQ-007 b  input  WIDTH  multiplier; sampled on the accepting edge only.
REQ-008 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when product is updated.
REQ-011 product  output  2*WIDTH  result register; holds last result until the next result is written.

Function
REQ-012 States SHALL be IDLE, MULT and FIX; busy SHALL be 1 exactly in MULT and FIX.
REQ-013 IDLE with start=1 at edge E0 SHALL do the following: latch |a|, |b| and the result sign (signed_mode & (a[MSB]^b[MSB])); clear the accumulator; enter MULT.
REQ-014 The effective digit count ka SHALL be the index of the highest nonzero DIGIT-slice of |a|, plus 1, with a minimum of 1; kb SHALL be defined the same way for |b|.
REQ-015 MULT SHALL add exactly one DIGITxDIGIT partial product per cycle, shifted by (i+j)*DIGIT, over all i<ka, j<kb, for ka*kb cycles; it SHALL then enter FIX.
REQ-016 FIX SHALL write product as the accumulator, negated if the latched sign is 1, and SHALL return to IDLE.
REQ-017 Latency: done=1 and busy=0 SHALL hold after edge E0+ka*kb+1; done SHALL stay high for exactly one cycle.
REQ-018 start SHALL be ignored while busy=1; operand changes during busy SHALL NOT affect the result.
REQ-019 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted, allowing back-to-back operations.
REQ-020 The magnitude of -2^(WIDTH-1) SHALL be handled as the unsigned value 2^(WIDTH-1); the 2*WIDTH result SHALL never overflow.
REQ-021 A zero operand SHALL take ka=kb=1 cycles and produce a product of 0.

Reset
REQ-022 reset=1 at any edge, including mid-operation, SHALL force IDLE, busy=0, done=0, product=0 and accumulator=0.
REQ-023 reset SHALL take priority over start.

Structure
REQ-024 Package mult_pkg SHALL hold the state enum (IDLE/MULT/FIX) and the default WIDTH/DIGIT constants.
REQ-025 The DIGITxDIGIT unsigned multiply SHALL be one sub-module, mult_digit, which is combinational and instantiated once.
REQ-026 The digit indices i/j SHALL be registered counters; no WIDTHxWIDTH multiplier SHALL be inferred.

Verification (WIDTH=32, DIGIT=16)
REQ-027 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> product 0xFFFFFFFE00000001; done 5 cycles after the start edge.
REQ-028 Unsigned 0x00001234 x 0x00000010 -> 0x0000000000012340; done 2 cycles after start (fast path, ka=kb=1).
REQ-029 Signed 0xFFFFFFFD (-3) x 0x00000007 -> 0xFFFFFFFFFFFFFFEB; done after 2 cycles. Signed 0x80000000 x 0x80000000 -> 0x4000000000000000; done after 5 cycles.
REQ-030 Start pulsed while busy with different a/b -> result unchanged; a second start in the done cycle -> second result is correct with the correct latency.
REQ-031 reset asserted in the second MULT cycle -> next cycle busy=0, done=0, product=0; a following start behaves normally.
REQ-032 a=0, b=0xDEADBEEF -> product 0; done after 2 cycles; the bench SHALL compare every result against a reference model and check the done timing.
